// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin mux source arbiter.
package arb_pkg;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr, wrapping.
module rr_picker
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             found,
  output sel_t             idx
);

  logic [N_REQ-1:0] rot;
  sel_t             off;

  // Rotate so ptr lands at bit 0, priority-encode lowest bit, then rotate back.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[sel_t'(int'(ptr) + i)];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
    found = |rot;
    idx   = ptr + off;
  end

endmodule

// File: rtl/mux_source_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 datapath mux,
// holding each grant until last beat, MAX_HOLD beats, or requester withdrawal.
module mux_source_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  input  logic             out_ready,
  output sel_t             sel,
  output logic [N_REQ-1:0] grant,
  output logic             out_valid,
  output logic             busy
);

  arb_state_t       state, state_nxt;
  sel_t             ptr, ptr_nxt;
  sel_t             sel_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             pick_found;
  sel_t             pick_idx;
  logic             xfer;
  logic             hold_done;

  rr_picker u_picker (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= '0;
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      grant    <= grant_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign busy      = (state == GRANT);
  assign out_valid = busy && req[sel];
  assign xfer      = out_valid && out_ready;
  assign hold_done = ({1'b0, beat_cnt} + 5'd1) == 5'(MAX_HOLD);

  // sel only moves on a new grant so the mux select never glitches while idle.
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    grant_nxt    = grant;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          sel_nxt      = pick_idx;
          grant_nxt    = N_REQ'(1) << pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel] || (xfer && (last[sel] || hold_done))) begin
          ptr_nxt   = sel + sel_t'(1);
          grant_nxt = '0;
          state_nxt = IDLE;
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
  a_grant_sel:    assert property (@(posedge clk) disable iff (!reset_n)
                                   (grant != '0) |-> (grant == (N_REQ'(1) << sel)));
  a_valid_busy:   assert property (@(posedge clk) disable iff (!reset_n) out_valid |-> busy);

endmodule

// File: tb/tb_mux_source_arbiter.sv
// Bench for mux_source_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mux_source_arbiter;
  localparam int unsigned MAXH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req, last;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       out_valid, busy;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  // behavioural model: who owns the mux, beats taken, where the scan starts
  bit m_busy;
  int m_sel, m_ptr, m_cnt;

  mux_source_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_release();
    m_ptr  = (m_sel + 1) % 8;
    m_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic [7:0] l, input logic rd);
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_sel  = (m_ptr + k) % 8;
          m_busy = 1'b1;
          m_cnt  = 0;
          break;
        end
      end
    end else if (!r[m_sel]) begin
      model_release();
    end else if (rd) begin
      m_cnt++;
      if (l[m_sel] || m_cnt == MAXH) model_release();
    end
  endtask

  // Called at a negedge: drive, check outputs, advance one clock.
  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rd);
    logic [7:0] eg;
    logic       ev;
    req = r; last = l; out_ready = rd;
    #1;
    eg = m_busy ? (8'h01 << m_sel) : 8'h00;
    ev = m_busy && r[m_sel];
    chk("grant", 32'(grant), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (out_valid && rd) xfers++;
    @(posedge clk);
    model_edge(r, l, rd);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // single requester, two beats ending on last
    xfers = 0;
    step(8'h08, 8'h00, 1'b1);
    step(8'h08, 8'h00, 1'b1);
    step(8'h08, 8'h08, 1'b1);
    step(8'h00, 8'h00, 1'b1);
    chk("single_beats", 32'(xfers), 32'd2);
    chk("single_ptr", 32'(dut.ptr), 32'd4);

    // round robin between 0 and 7 with wrap
    for (int i = 0; i < 10; i++) step(8'h81, 8'hFF, 1'b1);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // MAX_HOLD forced release, then regrant after one bubble
    xfers = 0;
    step(8'h04, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h04, 8'h00, 1'b1);
    chk("hold_beats", 32'(xfers), 32'd4);
    chk("hold_bubble", 32'(grant), 32'd0);
    step(8'h04, 8'h00, 1'b1);
    chk("hold_regrant", 32'(grant), 32'h04);
    step(8'h04, 8'h00, 1'b1);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // backpressure: beat_cnt frozen while out_ready low
    step(8'h02, 8'h00, 1'b0);
    step(8'h02, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(8'h02, 8'h00, 1'b0);
      chk("bp_cnt", 32'(dut.beat_cnt), 32'(m_cnt));
    end
    chk("bp_cnt_held", 32'(dut.beat_cnt), 32'd1);
    step(8'h02, 8'h02, 1'b1);
    step(8'h00, 8'h00, 1'b0);

    // withdrawal of requester 5 hands off to 6 without a transfer
    xfers = 0;
    step(8'h20, 8'h00, 1'b0);
    step(8'h20, 8'h00, 1'b0);
    step(8'h40, 8'h00, 1'b1);
    step(8'h40, 8'h00, 1'b1);
    chk("wd_beats", 32'(xfers), 32'd0);
    chk("wd_grant", 32'(grant), 32'h40);
    chk("wd_sel", 32'(sel), 32'd6);
    step(8'h40, 8'h40, 1'b1);

    // asynchronous reset in the middle of a grant
    step(8'hFF, 8'h00, 1'b0);
    step(8'hFF, 8'h00, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
